program_sequencer_stack: RTL and testbench

PROGRAM_SEQUENCER_STACK -- requirements
Module: program_sequencer_stack

---
 rtl/program_sequencer_stack_if.sv | 31 +++
 rtl/program_sequencer_stack.sv | 90 +++++++++
 tb/tb_program_sequencer_stack.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/program_sequencer_stack_if.sv
// Request/status bundle between a program sequencer and its controller.
// The master drives the requests and the slave (the sequencer) returns fetch address and stack status.
interface program_sequencer_stack_if #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic              stall;
  logic              jmp;
  logic              jmp_nz;
  logic              dont_jmp;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] jmp_addr;
  logic [ADDR_W-1:0] pm_addr;
  logic [LVL_W-1:0]  stack_level;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;

  modport master (
    output stall, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
    input  pm_addr, stack_level, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  stall, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
    output pm_addr, stack_level, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/program_sequencer_stack.sv
// Program counter with jump/branch/call/return and a LIFO return-address stack.
// Overflow and underflow are non-destructive: the PC just advances and a sticky error is raised.
module program_sequencer_stack #(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  program_sequencer_stack_if.slave  bus
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] pm_q, pm_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic              push;
  logic [ADDR_W-1:0] inc_addr;
  logic [ADDR_W-1:0] top_addr;
  logic              full;
  logic              empty;

  assign inc_addr = pm_q + ADDR_W'(1);
  assign full     = (level_q == LVL_W'(STACK_DEPTH));
  assign empty    = (level_q == '0);

  always_comb begin
    top_addr = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (level_q == LVL_W'(i + 1)) top_addr = stack_q[i];
    end
  end

  // Priority: ret > call > jmp > jmp_nz > increment; a blocked ret/call falls back to increment.
  always_comb begin
    pm_d    = pm_q;
    level_d = level_q;
    err_d   = err_q;
    push    = 1'b0;
    if (!bus.stall) begin
      pm_d = inc_addr;
      if (bus.ret) begin
        if (!empty) begin
          pm_d    = top_addr;
          level_d = level_q - LVL_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (bus.call) begin
        if (!full) begin
          push    = 1'b1;
          pm_d    = bus.jmp_addr;
          level_d = level_q + LVL_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (bus.jmp) begin
        pm_d = bus.jmp_addr;
      end else if (bus.jmp_nz && !bus.dont_jmp) begin
        pm_d = bus.jmp_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pm_q    <= RESET_ADDR;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pm_q    <= pm_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Entry contents are left alone on reset; a zero level makes them unreachable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && level_q == LVL_W'(i)) stack_q[i] <= inc_addr;
    end
  end

  assign bus.pm_addr     = pm_q;
  assign bus.stack_level = level_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_program_sequencer_stack.sv
// Scoreboard bench for program_sequencer_stack: each step queues the expected state and
// checks it one edge later; asynchronous reset is checked between edges.
module tb_program_sequencer_stack;
  localparam int ADDR_W      = 8;
  localparam int STACK_DEPTH = 4;
  localparam int LVL_W       = $clog2(STACK_DEPTH + 1);

  typedef struct {
    string             tag;
    logic [ADDR_W-1:0] pm;
    logic [LVL_W-1:0]  lvl;
    logic              err;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  program_sequencer_stack_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) bus ();

  program_sequencer_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .RESET_ADDR  (8'h00)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic j, input logic jnz, input logic dj,
                       input logic c, input logic r, input logic [ADDR_W-1:0] a);
    bus.stall    = st;
    bus.jmp      = j;
    bus.jmp_nz   = jnz;
    bus.dont_jmp = dj;
    bus.call     = c;
    bus.ret      = r;
    bus.jmp_addr = a;
  endtask

  task automatic step(input string tag, input logic st, input logic j, input logic jnz,
                      input logic dj, input logic c, input logic r, input logic [ADDR_W-1:0] a,
                      input logic [ADDR_W-1:0] e_pm, input logic [LVL_W-1:0] e_lvl,
                      input logic e_err);
    exp_t e;
    @(negedge clk);
    drive(st, j, jnz, dj, c, r, a);
    e.tag = tag;
    e.pm  = e_pm;
    e.lvl = e_lvl;
    e.err = e_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, " pm_addr"},     32'(bus.pm_addr),     32'(e.pm));
      chk({e.tag, " stack_level"}, 32'(bus.stack_level), 32'(e.lvl));
      chk({e.tag, " stack_err"},   32'(bus.stack_err),   32'(e.err));
      chk({e.tag, " stack_full"},  32'(bus.stack_full),  32'(e.lvl == LVL_W'(STACK_DEPTH)));
      chk({e.tag, " stack_empty"}, 32'(bus.stack_empty), 32'(e.lvl == '0));
    end
  endtask

  task automatic idle(input string tag, input logic [ADDR_W-1:0] e_pm,
                      input logic [LVL_W-1:0] e_lvl, input logic e_err);
    step(tag, 0, 0, 0, 0, 0, 0, '0, e_pm, e_lvl, e_err);
  endtask

  // Pulse reset between edges; state must follow immediately, and the first
  // clock edge after release performs a normal update.
  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, '0);
    reset_n = 1'b0;
    #1;
    chk({tag, " rst pm_addr"},     32'(bus.pm_addr),     32'h00);
    chk({tag, " rst stack_level"}, 32'(bus.stack_level), 32'd0);
    chk({tag, " rst stack_empty"}, 32'(bus.stack_empty), 32'd1);
    chk({tag, " rst stack_full"},  32'(bus.stack_full),  32'd0);
    chk({tag, " rst stack_err"},   32'(bus.stack_err),   32'd0);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, '0);
    #12;
    reset_n = 1'b1;

    // Free-running count with wrap at 256
    pulse_reset("wrap");
    for (int k = 1; k <= 260; k++) idle("wrap", ADDR_W'(k), 0, 0);

    // Single call / return
    pulse_reset("call");
    for (int k = 1; k <= 16; k++) idle("to10", ADDR_W'(k), 0, 0);
    step("call40", 0, 0, 0, 0, 1, 0, 8'h40, 8'h40, 1, 0);
    idle("sub41", 8'h41, 1, 0);
    idle("sub42", 8'h42, 1, 0);
    idle("sub43", 8'h43, 1, 0);
    step("ret11", 0, 0, 0, 0, 0, 1, 8'h00, 8'h11, 0, 0);

    // Nested calls, overflow, LIFO unwind
    step("nest1", 0, 0, 0, 0, 1, 0, 8'h50, 8'h50, 1, 0);
    step("nest2", 0, 0, 0, 0, 1, 0, 8'h60, 8'h60, 2, 0);
    step("nest3", 0, 0, 0, 0, 1, 0, 8'h70, 8'h70, 3, 0);
    step("nest4", 0, 0, 0, 0, 1, 0, 8'h80, 8'h80, 4, 0);
    step("ovfl",  0, 0, 0, 0, 1, 0, 8'h90, 8'h81, 4, 1);
    step("unw1",  0, 0, 0, 0, 0, 1, 8'h00, 8'h71, 3, 1);
    step("unw2",  0, 0, 0, 0, 0, 1, 8'h00, 8'h61, 2, 1);
    step("unw3",  0, 0, 0, 0, 0, 1, 8'h00, 8'h51, 1, 1);
    step("unw4",  0, 0, 0, 0, 0, 1, 8'h00, 8'h12, 0, 1);

    // Underflow sets a sticky error cleared only by reset
    pulse_reset("undf");
    for (int k = 1; k <= 5; k++) idle("to05", ADDR_W'(k), 0, 0);
    step("retempty", 0, 0, 0, 0, 0, 1, 8'h00, 8'h06, 0, 1);
    idle("sticky7", 8'h07, 0, 1);
    idle("sticky8", 8'h08, 0, 1);
    pulse_reset("errclr");

    // Conditional jump and priority
    step("jnz_dj1",  0, 0, 1, 1, 0, 0, 8'h20, 8'h01, 0, 0);
    step("jnz_dj0",  0, 0, 1, 0, 0, 0, 8'h20, 8'h20, 0, 0);
    step("call30",   0, 0, 0, 0, 1, 0, 8'h30, 8'h30, 1, 0);
    step("ret_wins", 0, 1, 0, 0, 1, 1, 8'h99, 8'h21, 0, 0);
    step("call_vs_jmp", 0, 1, 1, 0, 1, 0, 8'h40, 8'h40, 1, 0);
    step("jmp77",    0, 1, 1, 1, 0, 0, 8'h77, 8'h77, 1, 0);
    step("ret22",    0, 0, 0, 0, 0, 1, 8'h00, 8'h22, 0, 0);

    // Stall holds state and ignores requests
    step("stall1", 1, 0, 0, 0, 1, 0, 8'h55, 8'h22, 0, 0);
    step("stall2", 1, 0, 0, 0, 1, 0, 8'h55, 8'h22, 0, 0);
    step("stall3", 1, 0, 0, 0, 1, 0, 8'h55, 8'h22, 0, 0);
    step("call55", 0, 0, 0, 0, 1, 0, 8'h55, 8'h55, 1, 0);
    step("stallret", 1, 0, 0, 0, 0, 1, 8'h00, 8'h55, 1, 0);
    step("stallovf", 1, 0, 0, 0, 0, 0, 8'h00, 8'h55, 1, 0);

    // Reset mid-subroutine aborts; first edge after release increments from 0
    pulse_reset("midcall");
    idle("post_rst", 8'h01, 0, 0);

    // Return address wraps past 0xFF
    step("jmpFF",   0, 1, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 0);
    step("callwrap", 0, 0, 0, 0, 1, 0, 8'h10, 8'h10, 1, 0);
    step("retwrap", 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
